// File: rtl/rr_arbiter8_pkg.sv
// Shared constants and state type for the eight-requester round-robin arbiter.
package rr_arbiter8_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter8_onehot_dec3.sv
// 3-to-8 one-hot decoder with enable; all-zero output while disabled.
module onehot_dec3
    import rr_arbiter8_pkg::*;
(
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] onehot
);

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_dec
        assign onehot[gi] = en && (idx == IDX_W'(gi));
    end

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-requester round-robin arbiter with grant hold and bounded tenure.
// All outputs are registered; the decoded grant is formed from next-state index/valid.
module rr_arbiter8
    import rr_arbiter8_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic [CNT_W-1:0] hold_cnt
);

    localparam bit             LIMITED   = (MAX_HOLD != 0);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

    arb_state_t       state_reg, state_next;
    logic [IDX_W-1:0] last_ptr_reg, last_ptr_next;
    logic [IDX_W-1:0] idx_reg, idx_next;
    logic             valid_reg, valid_next;
    logic [CNT_W-1:0] hold_reg, hold_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic             release_hit;

    // Lowest set bit; caller guarantees r is nonzero when the result matters.
    function automatic logic [IDX_W-1:0] find_first(input logic [N_REQ-1:0] r);
        logic [IDX_W-1:0] res;
        res = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (r[i]) res = IDX_W'(i);
        end
        return res;
    endfunction

    // Requesters strictly above ptr win first; otherwise wrap to the lowest set bit,
    // which places ptr itself last in the rotation.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                                 input logic [IDX_W-1:0] ptr);
        logic [N_REQ-1:0] hi_mask;
        logic [N_REQ-1:0] masked;
        hi_mask = ~((N_REQ'(2) << ptr) - N_REQ'(1));
        masked  = r & hi_mask;
        return find_first((masked != '0) ? masked : r);
    endfunction

    assign release_hit = !req[idx_reg] || (LIMITED && (hold_reg == HOLD_LAST));

    always_comb begin
        state_next    = state_reg;
        last_ptr_next = last_ptr_reg;
        idx_next      = idx_reg;
        valid_next    = valid_reg;
        hold_next     = hold_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (req != '0) begin
                    idx_next   = rr_pick(req, last_ptr_reg);
                    valid_next = 1'b1;
                    hold_next  = '0;
                    state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (release_hit) begin
                    last_ptr_next = idx_reg;
                    if (req != '0) begin
                        // Back-to-back handover: no idle cycle between holders.
                        idx_next  = rr_pick(req, idx_reg);
                        hold_next = '0;
                    end else begin
                        state_next = ST_IDLE;
                        idx_next   = '0;
                        valid_next = 1'b0;
                        hold_next  = '0;
                    end
                end else if (hold_reg != '1) begin
                    hold_next = hold_reg + CNT_W'(1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    onehot_dec3 u_dec (
        .idx    (idx_next),
        .en     (valid_next),
        .onehot (grant_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            last_ptr_reg <= IDX_W'(N_REQ - 1);
            idx_reg      <= '0;
            valid_reg    <= 1'b0;
            hold_reg     <= '0;
            grant_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            last_ptr_reg <= last_ptr_next;
            idx_reg      <= idx_next;
            valid_reg    <= valid_next;
            hold_reg     <= hold_next;
            grant_reg    <= grant_next;
        end
    end

    assign grant       = grant_reg;
    assign grant_idx   = idx_reg;
    assign grant_valid = valid_reg;
    assign hold_cnt    = hold_reg;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8: directed vector table, rotation and random phases,
// with a reference-model scoreboard on a MAX_HOLD=4 and a MAX_HOLD=0 instance.
module tb_rr_arbiter8;

    typedef struct {
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic [7:0] hold;
    } exp_t;

    typedef struct {
        logic       rst;
        logic [7:0] req;
        logic [7:0] g;
        logic [2:0] idx;
        logic       v;
        logic [7:0] hold;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] req = 8'h00;

    logic [7:0] g4, g0, h4, h0;
    logic [2:0] i4, i0;
    logic       v4, v0;

    int checks = 0;
    int failures = 0;

    int m_v[2], m_idx[2], m_hold[2], m_last[2];
    int mh[2] = '{4, 0};
    exp_t sb_q[$];
    vec_t tbl[$];
    int wait_cnt[8];

    always #5 clk = ~clk;

    rr_arbiter8 #(.MAX_HOLD(4), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g4), .grant_idx(i4), .grant_valid(v4), .hold_cnt(h4)
    );

    rr_arbiter8 #(.MAX_HOLD(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .req(req),
        .grant(g0), .grant_idx(i0), .grant_valid(v0), .hold_cnt(h0)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic int m_pick(input logic [7:0] r, input int last);
        logic [15:0] d;
        d = {r, r};
        for (int k = 1; k <= 8; k++) begin
            if (d[last + k]) return (last + k) % 8;
        end
        return 0;
    endfunction

    task automatic model_step(input int u, input logic r, input logic [7:0] q);
        logic rel;
        if (r) begin
            m_v[u] = 0; m_idx[u] = 0; m_hold[u] = 0; m_last[u] = 7;
        end else if (m_v[u] == 0) begin
            if (q != 8'h00) begin
                m_idx[u] = m_pick(q, m_last[u]); m_v[u] = 1; m_hold[u] = 0;
            end
        end else begin
            rel = !q[m_idx[u]] || (mh[u] != 0 && m_hold[u] + 1 == mh[u]);
            if (rel) begin
                m_last[u] = m_idx[u];
                if (q != 8'h00) begin
                    m_idx[u] = m_pick(q, m_last[u]); m_hold[u] = 0;
                end else begin
                    m_v[u] = 0; m_idx[u] = 0; m_hold[u] = 0;
                end
            end else if (m_hold[u] < 255) begin
                m_hold[u]++;
            end
        end
    endtask

    // Drive one transaction, predict both instances, then compare after the edge.
    task automatic step(input logic r, input logic [7:0] q);
        exp_t e;
        rst = r;
        req = q;
        for (int u = 0; u < 2; u++) begin
            model_step(u, r, q);
            e.v    = (m_v[u] != 0);
            e.idx  = 3'(m_idx[u]);
            e.hold = 8'(m_hold[u]);
            e.g    = e.v ? (8'h01 << m_idx[u]) : 8'h00;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk("sb4_grant", 32'(g4), 32'(e.g));
        chk("sb4_idx",   32'(i4), 32'(e.idx));
        chk("sb4_valid", 32'(v4), 32'(e.v));
        chk("sb4_hold",  32'(h4), 32'(e.hold));
        e = sb_q.pop_front();
        chk("sb0_grant", 32'(g0), 32'(e.g));
        chk("sb0_idx",   32'(i0), 32'(e.idx));
        chk("sb0_valid", 32'(v0), 32'(e.v));
        chk("sb0_hold",  32'(h0), 32'(e.hold));
        $display("t=%0t rst=%0b req=%02h | h4: grant=%02h idx=%0d valid=%0b hold=%0d | h0: grant=%02h idx=%0d valid=%0b hold=%0d",
                 $time, r, q, g4, i4, v4, h4, g0, i0, v0, h0);
    endtask

    task automatic add(input logic r, input logic [7:0] q, input logic [7:0] g,
                       input logic [2:0] idx, input logic v, input logic [7:0] hold);
        vec_t t;
        t.rst = r; t.req = q; t.g = g; t.idx = idx; t.v = v; t.hold = hold;
        tbl.push_back(t);
    endtask

    initial begin
        int worst;
        logic [7:0] q;

        // Directed vectors checked against hand-derived values on the MAX_HOLD=4 instance.
        add(1'b1, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
        for (int k = 0; k < 5; k++) add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
        add(1'b0, 8'h81, 8'h01, 3'd0, 1'b1, 8'd0);
        add(1'b0, 8'h80, 8'h80, 3'd7, 1'b1, 8'd0);
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
        for (int k = 0; k < 12; k++) add(1'b0, 8'h08, 8'h08, 3'd3, 1'b1, 8'(k % 4));
        add(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 8'd0);
        add(1'b0, 8'h04, 8'h04, 3'd2, 1'b1, 8'd0);
        add(1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 8'd1);
        add(1'b1, 8'h24, 8'h00, 3'd0, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) add(1'b0, 8'h24, 8'h04, 3'd2, 1'b1, 8'(k));
        add(1'b0, 8'h24, 8'h20, 3'd5, 1'b1, 8'd0);

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].rst, tbl[n].req);
            chk("vec_grant", 32'(g4), 32'(tbl[n].g));
            chk("vec_idx",   32'(i4), 32'(tbl[n].idx));
            chk("vec_valid", 32'(v4), 32'(tbl[n].v));
            chk("vec_hold",  32'(h4), 32'(tbl[n].hold));
        end

        // Full request load: each holder keeps the grant exactly 4 cycles, no gaps.
        step(1'b1, 8'h00);
        for (int k = 0; k < 36; k++) begin
            step(1'b0, 8'hFF);
            chk("rot_idx",   32'(i4), 32'((k / 4) % 8));
            chk("rot_hold",  32'(h4), 32'(k % 4));
            chk("rot_valid", 32'(v4), 32'd1);
            chk("rot_grant", 32'(g4), 32'(8'h01 << ((k / 4) % 8)));
        end

        // Random requests: invariants and fairness on the unlimited-tenure instance.
        step(1'b1, 8'h00);
        for (int i = 0; i < 8; i++) wait_cnt[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            q = 8'($urandom_range(0, 255));
            step(1'b0, q);
            chk("onehot0", 32'($countones(g0) <= 1), 32'd1);
            chk("dec0", 32'(g0), 32'(v0 ? (8'h01 << i0) : 8'h00));
            chk("valid0", 32'(v0), 32'(g0 != 8'h00));
            if (v0 && h0 == 8'd0) begin
                chk("grant_req_high", 32'(q[i0]), 32'd1);
                worst = 0;
                for (int i = 0; i < 8; i++) begin
                    if (i == int'(i0)) wait_cnt[i] = 0;
                    else if (q[i]) wait_cnt[i]++;
                    if (wait_cnt[i] > worst) worst = wait_cnt[i];
                end
                chk("starve_bound", 32'(worst <= 8), 32'd1);
            end
            for (int i = 0; i < 8; i++) begin
                if (!q[i]) wait_cnt[i] = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
